axil_cmd_master: RTL

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

---
 rtl/axil_cmd_master.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response port.
// Registered AXI outputs, per-transaction timeout with forced error response.
module axil_cmd_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        axi_clk,
  input  logic        axi_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] cnt;
  logic        aw_ok;
  logic        w_ok;
  logic        done;
  logic        busy;
  logic        do_timeout;

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;
  assign m_wstrb  = 4'hF;

  // A channel counts as finished once its valid has dropped or it handshakes now
  assign aw_ok = !m_awvalid || m_awready;
  assign w_ok  = !m_wvalid || m_wready;

  always_comb begin
    done = 1'b0;
    busy = 1'b1;
    unique case (state)
      WR_REQ:  done = aw_ok && w_ok;
      WR_RESP: done = m_bvalid;
      RD_REQ:  done = m_arready;
      RD_DATA: done = m_rvalid;
      default: busy = 1'b0;
    endcase
  end

  // A completing handshake in the last allowed cycle beats the timeout
  assign do_timeout = busy && (cnt == TO_LAST) && !done;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_timeout <= 1'b0;
      m_awaddr    <= '0;
      m_awvalid   <= 1'b0;
      m_wdata     <= '0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_araddr    <= '0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
    end else begin
      if (busy && cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
      if (do_timeout) begin
        m_awvalid   <= 1'b0;
        m_wvalid    <= 1'b0;
        m_bready    <= 1'b0;
        m_arvalid   <= 1'b0;
        m_rready    <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_resp    <= 2'b10;
        rsp_rdata   <= '0;
        state       <= RSP;
      end else begin
        unique case (state)
          IDLE: begin
            cmd_ready <= 1'b1;
            if (cmd_valid && cmd_ready) begin
              cmd_ready <= 1'b0;
              cnt       <= '0;
              m_awaddr  <= cmd_addr & 32'hFFFF_FFFC;
              m_araddr  <= cmd_addr & 32'hFFFF_FFFC;
              m_wdata   <= cmd_wdata;
              if (cmd_write) begin
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
                state     <= WR_REQ;
              end else begin
                m_arvalid <= 1'b1;
                state     <= RD_REQ;
              end
            end
          end
          WR_REQ: begin
            if (m_awready) m_awvalid <= 1'b0;
            if (m_wready)  m_wvalid  <= 1'b0;
            if (aw_ok && w_ok) begin
              m_bready <= 1'b1;
              state    <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (m_bvalid) begin
              m_bready    <= 1'b0;
              rsp_resp    <= m_bresp;
              rsp_rdata   <= '0;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RSP;
            end
          end
          RD_REQ: begin
            if (m_arready) begin
              m_arvalid <= 1'b0;
              m_rready  <= 1'b1;
              state     <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (m_rvalid) begin
              m_rready    <= 1'b0;
              rsp_resp    <= m_rresp;
              rsp_rdata   <= m_rdata;
              rsp_timeout <= 1'b0;
              rsp_valid   <= 1'b1;
              state       <= RSP;
            end
          end
          RSP: begin
            if (rsp_ready) begin
              rsp_valid   <= 1'b0;
              rsp_timeout <= 1'b0;
              cmd_ready   <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
